// File: rtl/apb_mem_slave_p_if.sv
// APB4 bus bundle for apb_mem_slave_p: request signals from the master,
// response signals from the slave.
interface apb_mem_slave_p_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB4 memory slave: DEPTH words with byte strobes, programmable wait states
// and PSLVERR on misaligned or out-of-range accesses. Response is registered.
module apb_mem_slave_p #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  apb_mem_slave_p_if.slave  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  access;
  logic                  err;
  logic                  go_resp;
  logic                  wr_en;
  logic [IDX_W-1:0]      widx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pslverr_d;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] word;
    mask = ADDR_WIDTH'(STRB_W - 1);
    word = a >> LSB;
    return ((a & mask) != '0) || (32'(word) >= 32'(DEPTH));
  endfunction

  assign access  = bus.psel & bus.penable;
  assign err     = addr_err(bus.paddr);
  assign widx    = IDX_W'(bus.paddr >> LSB);
  assign rd_word = mem_q[widx];

  // The edge that enters RESP is the single commit point for writes and reads.
  always_comb begin
    go_resp = 1'b0;
    if (!reset && access) begin
      if (state_q == S_IDLE && WAIT_STATES == 0) go_resp = 1'b1;
      if (state_q == S_WAIT && cnt_q == 4'd1)    go_resp = 1'b1;
    end
  end

  assign wr_en = go_resp & bus.pwrite & ~err;

  always_comb begin
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;
    if (err) begin
      prdata_d  = '0;
      pslverr_d = 1'b1;
    end else if (!bus.pwrite) begin
      prdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.pstrb[i]) mem_q[widx][8*i +: 8] <= bus.pwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            cnt_q <= 4'(WAIT_STATES);
            if (go_resp) begin
              state_q   <= S_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= pslverr_d;
              prdata_q  <= prdata_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.psel) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (go_resp) begin
            state_q   <= S_RESP;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b1;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
          end else if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= 4'd0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule
